vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The block SHALL have parameters H_ACTIVE=640, H_FP=16, H_SYNC=96 and H_BP=48, giving horizontal pixel-clock phase lengths.
REQ-002 The block SHALL have parameters V_ACTIVE=480, V_FP=10, V_SYNC=2 and V_BP=33, giving vertical phase lengths in lines.
REQ-003 H_TOTAL SHALL be derived as the sum of the H_* parameters (800), and V_TOTAL as the sum of the V_* parameters (525).
REQ-004 clk  in  1  pixel clock, 25.175 MHz nominal.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 en  in  1  advance enable; 0 freezes timing.
REQ-007 x  out  10  current horizontal count, combinational from the counter.
REQ-008 y  out  10  current vertical count, combinational from the counter.
REQ-009 r_in, g_in, b_in  in  2 each  renderer colour for the current (x, y), valid in the same cycle.
REQ-010 r, g, b  out  2 each  registered colour to the pads.
REQ-011 hs, vs  out  1 each  registered active-low sync.
REQ-012 de  out  1  registered display-enable.
REQ-013 frame_start  out  1  registered one-cycle pulse at the first active pixel of a frame.

Function
REQ-014 The horizontal counter hc SHALL count 0..H_TOTAL-1 while en=1, and SHALL wrap to 0 after H_TOTAL-1.
REQ-015 The vertical counter vc SHALL increment only in the cycle hc wraps, and SHALL wrap to 0 after V_TOTAL-1.
REQ-016 When hc and vc are both at their maximum values, both counters SHALL wrap to 0 in the same cycle.
REQ-017 Each axis SHALL track its phase as a state machine ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
REQ-018 The horizontal state SHALL transition at hc = H_ACTIVE, H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC, and at the wrap.
REQ-019 The vertical state SHALL use the same boundary pattern on vc, with transitions occurring only on the hc wrap.
REQ-020 x SHALL equal hc and y SHALL equal vc, zero-extended to 10 bits; x and y are not clamped during blanking.
REQ-021 All registered outputs SHALL have exactly one cycle of latency relative to the x/y value they describe.
REQ-022 de SHALL be 1 only when both axes are in ACTIVE.
REQ-023 When de is 0, r, g and b SHALL be 0 regardless of r_in, g_in and b_in.
REQ-024 hs SHALL be 0 only while the horizontal state is SYNC, and vs SHALL be 0 only while the vertical state is SYNC.
REQ-025 frame_start SHALL be 1 for exactly one cycle, for the pixel hc=0, vc=0, and only if en=1 in that cycle.
REQ-026 With en=0, hc, vc and the state machines SHALL hold their values, and r, g, b, de and frame_start SHALL register 0.
REQ-027 With en=0, hs and vs SHALL register their held-state values, so the sync level is preserved across a stall.
REQ-028 When en returns to 1, counting SHALL resume from the held hc/vc with no skipped or repeated count.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately set hc=0, vc=0 and both state machines to ACTIVE.
REQ-030 Asserting rst_n=0 SHALL immediately set r=g=b=0, hs=1, vs=1, de=0 and frame_start=0.
REQ-031 Asserting reset mid-line or mid-sync SHALL abort the frame; after release, the first en=1 cycle SHALL present hc=0, vc=0 and produce frame_start one cycle later.

Configuration
REQ-032 When the macro VGA_BORDER_EN is defined, pixels at x=0, x=H_ACTIVE-1, y=0 or y=V_ACTIVE-1 with de=1 SHALL output r=g=b=2'b11, overriding the *_in inputs.
REQ-033 When VGA_BORDER_EN is undefined, active pixels SHALL pass r_in, g_in and b_in through unchanged, and no border logic SHALL be synthesised.

Verification
REQ-034 Reset check: rst_n=0 asynchronously mid-frame -> outputs reach their reset values (REQ-030) without a clock edge; after release with en=1, frame_start pulses exactly once, 1 cycle after hc=0, vc=0.
REQ-035 Horizontal timing: en=1 for one line -> hs low for exactly 96 cycles, starting 1 cycle after hc=656; de high for exactly 640 cycles per active line.
REQ-036 Frame timing: free-run for 2 frames -> frame_start period exactly 420000 cycles; vs low exactly during lines 490-491 (1600 cycles), delayed 1 cycle.
REQ-037 Blanking: r_in=g_in=b_in=2'b11 held constant -> r=g=b=0 whenever de=0; 2'b11 whenever de=1 (build without VGA_BORDER_EN).
REQ-038 Stall: en=0 for 10 cycles at hc=700 (inside hsync) -> x and y frozen, hs stays 0, de=0; resume -> next x=701.
REQ-039 Border (VGA_BORDER_EN defined): r_in=g_in=b_in=0 -> outputs 2'b11 at (0,0), (639,5) and (5,479); outputs 0 at (1,1).

Source files
------------

// File: rtl/vga_timing_if.sv
// VGA timing bus: renderer-facing colour/position and pad-facing sync/colour.
// slave = timing generator side, master = renderer/pad side.
interface vga_timing_if;
  logic       en;
  logic [9:0] x;
  logic [9:0] y;
  logic [1:0] r_in;
  logic [1:0] g_in;
  logic [1:0] b_in;
  logic [1:0] r;
  logic [1:0] g;
  logic [1:0] b;
  logic       hs;
  logic       vs;
  logic       de;
  logic       frame_start;

  modport slave (
    input  en, r_in, g_in, b_in,
    output x, y, r, g, b, hs, vs, de, frame_start
  );

  modport master (
    output en, r_in, g_in, b_in,
    input  x, y, r, g, b, hs, vs, de, frame_start
  );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator with registered sync/colour outputs.
// Optional VGA_BORDER_EN forces a white frame border on active pixels.
module vga_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_timing_if.slave  vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last count of each phase; the state moves on the following cycle.
  localparam logic [9:0] H_A_END = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_F_END = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_S_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_A_END = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_F_END = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_S_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } phase_e;

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  phase_e     hst_q, hst_d;
  phase_e     vst_q, vst_d;

  logic [5:0] rgb_q, rgb_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       de_q, de_d;
  logic       fs_q, fs_d;

  logic       hwrap;
  logic       vwrap;
  logic [5:0] pix;

  assign hwrap = (hc_q == H_LAST);
  assign vwrap = (vc_q == V_LAST);

`ifdef VGA_BORDER_EN
  logic border;
  assign border = (hc_q == '0) || (hc_q == H_A_END) ||
                  (vc_q == '0) || (vc_q == V_A_END);
  assign pix = border ? 6'h3f : {vif.r_in, vif.g_in, vif.b_in};
`else
  assign pix = {vif.r_in, vif.g_in, vif.b_in};
`endif

  always_comb begin
    hc_d  = hc_q;
    vc_d  = vc_q;
    hst_d = hst_q;
    vst_d = vst_q;
    if (vif.en) begin
      hc_d = hwrap ? '0 : hc_q + 10'd1;
      unique case (hst_q)
        ACTIVE: if (hc_q == H_A_END) hst_d = FRONT;
        FRONT:  if (hc_q == H_F_END) hst_d = SYNC;
        SYNC:   if (hc_q == H_S_END) hst_d = BACK;
        BACK:   if (hwrap)           hst_d = ACTIVE;
        default: hst_d = ACTIVE;
      endcase
      if (hwrap) begin
        vc_d = vwrap ? '0 : vc_q + 10'd1;
        unique case (vst_q)
          ACTIVE: if (vc_q == V_A_END) vst_d = FRONT;
          FRONT:  if (vc_q == V_F_END) vst_d = SYNC;
          SYNC:   if (vc_q == V_S_END) vst_d = BACK;
          BACK:   if (vwrap)           vst_d = ACTIVE;
          default: vst_d = ACTIVE;
        endcase
      end
    end
  end

  // Sync follows the held phase even when stalled, so levels survive en=0.
  always_comb begin
    de_d  = vif.en && (hst_q == ACTIVE) && (vst_q == ACTIVE);
    hs_d  = (hst_q != SYNC);
    vs_d  = (vst_q != SYNC);
    fs_d  = vif.en && (hc_q == '0) && (vc_q == '0);
    rgb_d = de_d ? pix : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q  <= '0;
      vc_q  <= '0;
      hst_q <= ACTIVE;
      vst_q <= ACTIVE;
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      hc_q  <= hc_d;
      vc_q  <= vc_d;
      hst_q <= hst_d;
      vst_q <= vst_d;
      rgb_q <= rgb_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      fs_q  <= fs_d;
    end
  end

  assign vif.x           = hc_q;
  assign vif.y           = vc_q;
  assign vif.r           = rgb_q[5:4];
  assign vif.g           = rgb_q[3:2];
  assign vif.b           = rgb_q[1:0];
  assign vif.hs          = hs_q;
  assign vif.vs          = vs_q;
  assign vif.de          = de_q;
  assign vif.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: raster model checked every cycle plus literal pins.
// Vertical timing is shortened so two frames fit in a short run.
module tb_vga_timing;

  localparam int HA = 640;
  localparam int HF = 16;
  localparam int HS = 96;
  localparam int HB = 48;
  localparam int VA = 6;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  vga_timing_if vif ();

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vif   (vif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t",
                 nm, act, exp, $time);
    end
  endtask

  // Raster model: position counters plus range rules per phase.
  int       mx, my;
  logic     e_de, e_hs, e_vs, e_fs;
  logic [5:0] e_rgb;

  function automatic logic [5:0] exp_pix(input int px, input int py,
                                         input logic [5:0] in);
`ifdef VGA_BORDER_EN
    if (px == 0 || px == HA - 1 || py == 0 || py == VA - 1)
      return 6'h3f;
`endif
    return in;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx    <= 0;
      my    <= 0;
      e_de  <= 1'b0;
      e_hs  <= 1'b1;
      e_vs  <= 1'b1;
      e_fs  <= 1'b0;
      e_rgb <= '0;
    end else begin
      e_de  <= vif.en && mx < HA && my < VA;
      e_hs  <= !(mx >= HA + HF && mx < HA + HF + HS);
      e_vs  <= !(my >= VA + VF && my < VA + VF + VS);
      e_fs  <= vif.en && mx == 0 && my == 0;
      e_rgb <= (vif.en && mx < HA && my < VA) ?
               exp_pix(mx, my, {vif.r_in, vif.g_in, vif.b_in}) : 6'h00;
      if (vif.en) begin
        if (mx == HT - 1) begin
          mx <= 0;
          my <= (my == VT - 1) ? 0 : my + 1;
        end else begin
          mx <= mx + 1;
        end
      end
    end
  end

  // Per-cycle compare and run-length trackers.
  logic chk_on = 1'b0;
  int cyc = 0;
  int hs_run = 0, hs_last = 0;
  int de_run = 0, de_last = 0;
  int vs_run = 0, vs_last = 0;
  int fs_n = 0, fs_t = 0, fs_prev = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_on) begin
        check("x", int'(vif.x), mx);
        check("y", int'(vif.y), my);
        check("de", int'(vif.de), int'(e_de));
        check("hs", int'(vif.hs), int'(e_hs));
        check("vs", int'(vif.vs), int'(e_vs));
        check("frame_start", int'(vif.frame_start), int'(e_fs));
        check("rgb", int'({vif.r, vif.g, vif.b}), int'(e_rgb));
      end
      if (!vif.hs) hs_run++;
      else if (hs_run > 0) begin hs_last = hs_run; hs_run = 0; end
      if (vif.de) de_run++;
      else if (de_run > 0) begin de_last = de_run; de_run = 0; end
      if (!vif.vs) vs_run++;
      else if (vs_run > 0) begin vs_last = vs_run; vs_run = 0; end
      if (vif.frame_start) begin
        fs_n++;
        fs_prev = fs_t;
        fs_t = cyc;
      end
    end
  end

  task automatic wait_xy(input int wx, input int wy, input int budget);
    int k;
    k = 0;
    while (!(int'(vif.x) == wx && int'(vif.y) == wy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_xy_in_time", int'(k < budget), 1);
  endtask

  task automatic set_in(input logic [5:0] v);
    {vif.r_in, vif.g_in, vif.b_in} = v;
  endtask

  logic [5:0] pats [4];
  int base;
  int k;

  initial begin
    pats[0] = 6'h3f;
    pats[1] = 6'h15;
    pats[2] = 6'h2a;
    pats[3] = 6'h24;
    vif.en = 1'b0;
    set_in(6'h3f);
    repeat (3) @(negedge clk);

    check("rst_x", int'(vif.x), 0);
    check("rst_y", int'(vif.y), 0);
    check("rst_hs", int'(vif.hs), 1);
    check("rst_vs", int'(vif.vs), 1);
    check("rst_de", int'(vif.de), 0);
    check("rst_fs", int'(vif.frame_start), 0);
    check("rst_rgb", int'({vif.r, vif.g, vif.b}), 0);

    chk_on = 1'b1;
    rst_n = 1'b1;
    vif.en = 1'b1;
    base = fs_n;
    @(negedge clk);
    check("first_fs", int'(vif.frame_start), 1);
    check("first_rgb_00", int'({vif.r, vif.g, vif.b}), 6'h3f);
    check("first_x", int'(vif.x), 1);

    k = 0;
    while (fs_n < base + 3 && k < 3 * HT * VT) begin
      @(negedge clk);
      k++;
    end
    check("two_frames_in_time", int'(k < 3 * HT * VT), 1);
    check("fs_period", fs_t - fs_prev, HT * VT);
    check("hs_low_len", hs_last, 96);
    check("de_high_len", de_last, 640);
    check("vs_low_len", vs_last, 1600);

    wait_xy(700, 1, 2 * HT * VT);
    vif.en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("stall_x", int'(vif.x), 700);
      check("stall_y", int'(vif.y), 1);
      check("stall_hs", int'(vif.hs), 0);
      check("stall_de", int'(vif.de), 0);
    end
    vif.en = 1'b1;
    @(negedge clk);
    check("resume_x", int'(vif.x), 701);

    for (int i = 0; i < 3000; i++) begin
      set_in(pats[i % 4]);
      @(negedge clk);
    end

    wait_xy(700, 4, 2 * HT * VT);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_x", int'(vif.x), 0);
    check("async_y", int'(vif.y), 0);
    check("async_hs", int'(vif.hs), 1);
    check("async_vs", int'(vif.vs), 1);
    check("async_de", int'(vif.de), 0);
    check("async_fs", int'(vif.frame_start), 0);
    check("async_rgb", int'({vif.r, vif.g, vif.b}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = fs_n;
    @(negedge clk);
    check("post_rst_fs", int'(vif.frame_start), 1);
    repeat (900) @(negedge clk);
    check("post_rst_fs_once", fs_n - base, 1);

`ifdef VGA_BORDER_EN
    set_in(6'h00);
    wait_xy(1, 1, 2 * HT * VT);
    @(negedge clk);
    check("border_1_1", int'({vif.r, vif.g, vif.b}), 0);
    wait_xy(639, 2, 2 * HT * VT);
    @(negedge clk);
    check("border_639_2", int'({vif.r, vif.g, vif.b}), 6'h3f);
    wait_xy(5, VA - 1, 2 * HT * VT);
    @(negedge clk);
    check("border_5_last", int'({vif.r, vif.g, vif.b}), 6'h3f);
    wait_xy(0, 0, 2 * HT * VT);
    @(negedge clk);
    check("border_0_0", int'({vif.r, vif.g, vif.b}), 6'h3f);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
